// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV64 pipeline: E-stage forwarding
// selects, stall/flush enables, post-reset flush sequence and data-memory timeout watchdog.
module hazard_ctrl #(
    parameter int RESET_FLUSH_CYCLES = 3,
    parameter int MEM_TIMEOUT        = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    input  logic [4:0] rs1_e,
    input  logic [4:0] rs2_e,
    input  logic [4:0] rd_e,
    input  logic       result_src_e,
    input  logic       pc_src_e,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_w,
    input  logic       mem_req_m,
    input  logic       mem_ack_m,
    output logic [1:0] forward_a_e,
    output logic [1:0] forward_b_e,
    output logic       stall_f,
    output logic       stall_d,
    output logic       stall_e,
    output logic       stall_m,
    output logic       flush_d,
    output logic       flush_e,
    output logic       mem_timeout_err
);

    localparam int IW = $clog2(RESET_FLUSH_CYCLES + 1);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [IW-1:0] INIT_LAST = IW'(RESET_FLUSH_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERR      = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [IW-1:0]   init_cnt_r;
    logic [IW-1:0]   init_cnt_s;
    logic [WW-1:0]   wait_cnt_r;
    logic [WW-1:0]   wait_cnt_s;
    logic            err_r;
    logic            err_s;
    logic            lw_stall_s;
    logic [1:0]      fwd_a_s;
    logic [1:0]      fwd_b_s;

    // M-stage result has priority over W-stage; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rdm, input logic wm,
                                           input logic [4:0] rdw, input logic ww);
        logic [1:0] sel;
        if ((rs != 5'd0) && (rs == rdm) && wm) begin
            sel = 2'b10;
        end else if ((rs != 5'd0) && (rs == rdw) && ww) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign fwd_a_s    = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
    assign fwd_b_s    = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
    assign lw_stall_s = result_src_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    assign mem_timeout_err = err_r;

    // State, counters and sticky error register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_INIT;
            init_cnt_r <= '0;
            wait_cnt_r <= '0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            init_cnt_r <= init_cnt_s;
            wait_cnt_r <= wait_cnt_s;
            err_r      <= err_s;
        end
    end

    // Next-state, counter updates and stall/flush/forward decode.
    always_comb begin
        state_s     = state_r;
        init_cnt_s  = init_cnt_r;
        wait_cnt_s  = wait_cnt_r;
        err_s       = err_r;
        forward_a_e = 2'b00;
        forward_b_e = 2'b00;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        if (!rst_n) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else begin
            case (state_r)
                ST_INIT: begin
                    stall_f = 1'b1;
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                    if (init_cnt_r == INIT_LAST) begin
                        state_s = ST_RUN;
                    end else begin
                        init_cnt_s = init_cnt_r + IW'(1);
                    end
                end
                ST_RUN: begin
                    forward_a_e = fwd_a_s;
                    forward_b_e = fwd_b_s;
                    if (mem_req_m && !mem_ack_m) begin
                        stall_f    = 1'b1;
                        stall_d    = 1'b1;
                        stall_e    = 1'b1;
                        stall_m    = 1'b1;
                        state_s    = ST_MEM_WAIT;
                        wait_cnt_s = WW'(1);
                    end else begin
                        stall_f = lw_stall_s;
                        stall_d = lw_stall_s;
                        flush_d = pc_src_e;
                        flush_e = lw_stall_s || pc_src_e;
                    end
                end
                ST_MEM_WAIT: begin
                    forward_a_e = fwd_a_s;
                    forward_b_e = fwd_b_s;
                    if (mem_ack_m) begin
                        // Frozen stages resume this cycle, so hazards apply again.
                        stall_f    = lw_stall_s;
                        stall_d    = lw_stall_s;
                        flush_d    = pc_src_e;
                        flush_e    = lw_stall_s || pc_src_e;
                        state_s    = ST_RUN;
                        wait_cnt_s = '0;
                    end else begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        stall_m = 1'b1;
                        if (wait_cnt_r == WAIT_MAX) begin
                            state_s = ST_ERR;
                            err_s   = 1'b1;
                        end else begin
                            wait_cnt_s = wait_cnt_r + WW'(1);
                        end
                    end
                end
                ST_ERR: begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    stall_m = 1'b1;
                    err_s   = 1'b1;
                end
                default: begin
                    state_s = ST_INIT;
                end
            endcase
        end
    end

endmodule
